// File: rtl/vdispatcher_pkg.sv
// Shared widths, add/sub encodings and slot record for the vector-lane dispatcher.
package vdispatcher_pkg;

   localparam int unsigned VD_INSTRWIDTH = 151;
   localparam int unsigned VD_ELMWIDTH   = 6;
   localparam int unsigned VD_CNTWIDTH   = 4;

   localparam logic ADD = 1'b0;
   localparam logic SUB = 1'b1;

   typedef struct packed {
      logic [VD_INSTRWIDTH-1:0] instr;
      logic                     first;
      logic [VD_ELMWIDTH-1:0]   rdelm;
      logic [VD_ELMWIDTH-1:0]   wrelm;
      logic [VD_CNTWIDTH-1:0]   count;
      logic                     valid;
   } slot_t;

endpackage

// File: rtl/vdispatcher_slot.sv
// One dispatcher slot: load/shift/hold source mux, pointer/count update, squash.
// VDISPATCHER_COUNT_SATURATE_EN selects saturating count arithmetic (default wraps).
module vdispatcher_slot
   import vdispatcher_pkg::*;
#(
   parameter int unsigned INSTRWIDTH = VD_INSTRWIDTH,
   parameter int unsigned ELMWIDTH   = VD_ELMWIDTH,
   parameter int unsigned CNTWIDTH   = VD_CNTWIDTH
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  i_load,
   input  logic                  i_shift,
   input  logic                  i_squash,
   input  logic                  i_own_inc,
   input  logic                  i_prev_inc,
   input  logic [INSTRWIDTH-1:0] i_par_instr,
   input  logic                  i_par_first,
   input  logic [ELMWIDTH-1:0]   i_par_rdelm,
   input  logic [ELMWIDTH-1:0]   i_par_wrelm,
   input  logic [CNTWIDTH-1:0]   i_par_count,
   input  logic                  i_par_valid,
   input  logic [INSTRWIDTH-1:0] i_prev_instr,
   input  logic                  i_prev_first,
   input  logic [ELMWIDTH-1:0]   i_prev_rdelm,
   input  logic [ELMWIDTH-1:0]   i_prev_wrelm,
   input  logic [CNTWIDTH-1:0]   i_prev_count,
   input  logic                  i_prev_valid,
   input  logic                  i_rdelm_add_sub,
   input  logic                  i_wrelm_add_sub,
   input  logic                  i_count_add_sub,
   input  logic [ELMWIDTH-1:0]   i_rdelm_step,
   input  logic [ELMWIDTH-1:0]   i_wrelm_step,
   input  logic [CNTWIDTH-1:0]   i_count_step,
   output logic [INSTRWIDTH-1:0] o_instr,
   output logic                  o_first,
   output logic [ELMWIDTH-1:0]   o_rdelm,
   output logic [ELMWIDTH-1:0]   o_wrelm,
   output logic [CNTWIDTH-1:0]   o_count,
   output logic                  o_valid
);

   logic [INSTRWIDTH-1:0] r_instr;
   logic                  r_first;
   logic [ELMWIDTH-1:0]   r_rdelm;
   logic [ELMWIDTH-1:0]   r_wrelm;
   logic [CNTWIDTH-1:0]   r_count;
   logic                  r_valid;

   logic [INSTRWIDTH-1:0] w_src_instr;
   logic                  w_src_first;
   logic [ELMWIDTH-1:0]   w_src_rdelm;
   logic [ELMWIDTH-1:0]   w_src_wrelm;
   logic [CNTWIDTH-1:0]   w_src_count;
   logic                  w_src_valid;
   logic                  w_src_inc;
   logic                  w_do_inc;
   logic [ELMWIDTH-1:0]   w_rdelm_upd;
   logic [ELMWIDTH-1:0]   w_wrelm_upd;
   logic [CNTWIDTH-1:0]   w_cnt_upd;
`ifdef VDISPATCHER_COUNT_SATURATE_EN
   logic [CNTWIDTH:0]     w_cnt_wide;
`endif

   // Increment follows the source slot, so on shift it is the upstream slot's bit.
   always_comb begin
      w_src_instr = r_instr;
      w_src_first = r_first;
      w_src_rdelm = r_rdelm;
      w_src_wrelm = r_wrelm;
      w_src_count = r_count;
      w_src_valid = r_valid;
      w_src_inc   = i_own_inc;
      if (i_load) begin
         w_src_instr = i_par_instr;
         w_src_first = i_par_first;
         w_src_rdelm = i_par_rdelm;
         w_src_wrelm = i_par_wrelm;
         w_src_count = i_par_count;
         w_src_valid = i_par_valid;
         w_src_inc   = 1'b0;
      end else if (i_shift) begin
         w_src_instr = i_prev_instr;
         w_src_first = i_prev_first;
         w_src_rdelm = i_prev_rdelm;
         w_src_wrelm = i_prev_wrelm;
         w_src_count = i_prev_count;
         w_src_valid = i_prev_valid;
         w_src_inc   = i_prev_inc;
      end
   end

   assign w_do_inc    = w_src_inc & w_src_valid;
   assign w_rdelm_upd = (i_rdelm_add_sub == ADD) ? w_src_rdelm + i_rdelm_step : w_src_rdelm - i_rdelm_step;
   assign w_wrelm_upd = (i_wrelm_add_sub == ADD) ? w_src_wrelm + i_wrelm_step : w_src_wrelm - i_wrelm_step;

   always_comb begin
`ifdef VDISPATCHER_COUNT_SATURATE_EN
      w_cnt_wide = {1'b0, w_src_count} + {1'b0, i_count_step};
      if (i_count_add_sub == SUB)
         w_cnt_upd = (i_count_step > w_src_count) ? '0 : w_src_count - i_count_step;
      else
         w_cnt_upd = w_cnt_wide[CNTWIDTH] ? '1 : w_cnt_wide[CNTWIDTH-1:0];
`else
      w_cnt_upd = (i_count_add_sub == SUB) ? w_src_count - i_count_step : w_src_count + i_count_step;
`endif
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_instr <= '0;
         r_first <= 1'b0;
         r_rdelm <= '0;
         r_wrelm <= '0;
         r_count <= '0;
         r_valid <= 1'b0;
      end else begin
         r_instr <= w_src_instr;
         r_first <= w_do_inc ? 1'b0 : w_src_first;
         r_rdelm <= w_do_inc ? w_rdelm_upd : w_src_rdelm;
         r_wrelm <= w_do_inc ? w_wrelm_upd : w_src_wrelm;
         r_count <= w_do_inc ? w_cnt_upd : w_src_count;
         r_valid <= w_src_valid & ~i_squash;
      end
   end

   assign o_instr = r_instr;
   assign o_first = r_first;
   assign o_rdelm = r_rdelm;
   assign o_wrelm = r_wrelm;
   assign o_count = r_count;
   assign o_valid = r_valid;

endmodule

// File: rtl/vdispatcher_multi.sv
// Chain of NUMSLOTS vector dispatch slots with shift/rotate, parallel load and squash.
// VDISPATCHER_COUNT_SATURATE_EN selects saturating count arithmetic (default wraps).
module vdispatcher_multi
   import vdispatcher_pkg::*;
#(
   parameter int unsigned NUMSLOTS   = 2,
   parameter int unsigned INSTRWIDTH = VD_INSTRWIDTH,
   parameter int unsigned ELMWIDTH   = VD_ELMWIDTH,
   parameter int unsigned CNTWIDTH   = VD_CNTWIDTH
) (
   input  logic                           clk,
   input  logic                           resetn,
   input  logic                           shift,
   input  logic                           rotate,
   input  logic                           load,
   input  logic [NUMSLOTS-1:0]            squash,
   input  logic [NUMSLOTS-1:0]            increment,
   input  logic [INSTRWIDTH-1:0]          inshift_instr,
   input  logic                           inshift_first,
   input  logic [ELMWIDTH-1:0]            inshift_rdelm,
   input  logic [ELMWIDTH-1:0]            inshift_wrelm,
   input  logic [CNTWIDTH-1:0]            inshift_count,
   input  logic                           inshift_valid,
   input  logic [NUMSLOTS*INSTRWIDTH-1:0] inparallel_instr,
   input  logic [NUMSLOTS-1:0]            inparallel_first,
   input  logic [NUMSLOTS*ELMWIDTH-1:0]   inparallel_rdelm,
   input  logic [NUMSLOTS*ELMWIDTH-1:0]   inparallel_wrelm,
   input  logic [NUMSLOTS*CNTWIDTH-1:0]   inparallel_count,
   input  logic [NUMSLOTS-1:0]            inparallel_valid,
   input  logic                           rdelm_add_sub,
   input  logic                           wrelm_add_sub,
   input  logic                           count_add_sub,
   input  logic [ELMWIDTH-1:0]            rdelm_valuetoadd,
   input  logic [ELMWIDTH-1:0]            wrelm_valuetoadd,
   input  logic [CNTWIDTH-1:0]            count_valuetoadd,
   output logic [NUMSLOTS*INSTRWIDTH-1:0] instr,
   output logic [NUMSLOTS-1:0]            first,
   output logic [NUMSLOTS*ELMWIDTH-1:0]   rdelm,
   output logic [NUMSLOTS*ELMWIDTH-1:0]   wrelm,
   output logic [NUMSLOTS*CNTWIDTH-1:0]   count,
   output logic [NUMSLOTS-1:0]            valid,
   output logic [NUMSLOTS-1:0]            done
);

   for (genvar gi = 0; gi < NUMSLOTS; gi++) begin : g_slot
      logic [INSTRWIDTH-1:0] w_prev_instr;
      logic                  w_prev_first;
      logic [ELMWIDTH-1:0]   w_prev_rdelm;
      logic [ELMWIDTH-1:0]   w_prev_wrelm;
      logic [CNTWIDTH-1:0]   w_prev_count;
      logic                  w_prev_valid;
      logic                  w_prev_inc;

      // Slot 0 takes either fresh inshift data (never incremented) or the wrapped tail.
      if (gi == 0) begin : g_head
         assign w_prev_instr = rotate ? instr[(NUMSLOTS-1)*INSTRWIDTH +: INSTRWIDTH] : inshift_instr;
         assign w_prev_first = rotate ? first[NUMSLOTS-1] : inshift_first;
         assign w_prev_rdelm = rotate ? rdelm[(NUMSLOTS-1)*ELMWIDTH +: ELMWIDTH] : inshift_rdelm;
         assign w_prev_wrelm = rotate ? wrelm[(NUMSLOTS-1)*ELMWIDTH +: ELMWIDTH] : inshift_wrelm;
         assign w_prev_count = rotate ? count[(NUMSLOTS-1)*CNTWIDTH +: CNTWIDTH] : inshift_count;
         assign w_prev_valid = rotate ? valid[NUMSLOTS-1] : inshift_valid;
         assign w_prev_inc   = rotate & increment[NUMSLOTS-1];
      end else begin : g_body
         assign w_prev_instr = instr[(gi-1)*INSTRWIDTH +: INSTRWIDTH];
         assign w_prev_first = first[gi-1];
         assign w_prev_rdelm = rdelm[(gi-1)*ELMWIDTH +: ELMWIDTH];
         assign w_prev_wrelm = wrelm[(gi-1)*ELMWIDTH +: ELMWIDTH];
         assign w_prev_count = count[(gi-1)*CNTWIDTH +: CNTWIDTH];
         assign w_prev_valid = valid[gi-1];
         assign w_prev_inc   = increment[gi-1];
      end

      vdispatcher_slot #(
         .INSTRWIDTH (INSTRWIDTH),
         .ELMWIDTH   (ELMWIDTH),
         .CNTWIDTH   (CNTWIDTH)
      ) u_slot (
         .clk             (clk),
         .resetn          (resetn),
         .i_load          (load),
         .i_shift         (shift),
         .i_squash        (squash[gi]),
         .i_own_inc       (increment[gi]),
         .i_prev_inc      (w_prev_inc),
         .i_par_instr     (inparallel_instr[gi*INSTRWIDTH +: INSTRWIDTH]),
         .i_par_first     (inparallel_first[gi]),
         .i_par_rdelm     (inparallel_rdelm[gi*ELMWIDTH +: ELMWIDTH]),
         .i_par_wrelm     (inparallel_wrelm[gi*ELMWIDTH +: ELMWIDTH]),
         .i_par_count     (inparallel_count[gi*CNTWIDTH +: CNTWIDTH]),
         .i_par_valid     (inparallel_valid[gi]),
         .i_prev_instr    (w_prev_instr),
         .i_prev_first    (w_prev_first),
         .i_prev_rdelm    (w_prev_rdelm),
         .i_prev_wrelm    (w_prev_wrelm),
         .i_prev_count    (w_prev_count),
         .i_prev_valid    (w_prev_valid),
         .i_rdelm_add_sub (rdelm_add_sub),
         .i_wrelm_add_sub (wrelm_add_sub),
         .i_count_add_sub (count_add_sub),
         .i_rdelm_step    (rdelm_valuetoadd),
         .i_wrelm_step    (wrelm_valuetoadd),
         .i_count_step    (count_valuetoadd),
         .o_instr         (instr[gi*INSTRWIDTH +: INSTRWIDTH]),
         .o_first         (first[gi]),
         .o_rdelm         (rdelm[gi*ELMWIDTH +: ELMWIDTH]),
         .o_wrelm         (wrelm[gi*ELMWIDTH +: ELMWIDTH]),
         .o_count         (count[gi*CNTWIDTH +: CNTWIDTH]),
         .o_valid         (valid[gi])
      );

      assign done[gi] = valid[gi] & (count[gi*CNTWIDTH +: CNTWIDTH] == '0);
   end

endmodule

// File: tb/tb_vdispatcher_multi.sv
// Directed bench for vdispatcher_multi with four slots; honours VDISPATCHER_COUNT_SATURATE_EN.
module tb_vdispatcher_multi;
   import vdispatcher_pkg::*;

   localparam int unsigned N  = 4;
   localparam int unsigned IW = VD_INSTRWIDTH;
   localparam int unsigned EW = VD_ELMWIDTH;
   localparam int unsigned CW = VD_CNTWIDTH;

   logic              clk = 1'b0;
   logic              resetn;
   logic              shift, rotate, load;
   logic [N-1:0]      squash, increment;
   logic [IW-1:0]     inshift_instr;
   logic              inshift_first, inshift_valid;
   logic [EW-1:0]     inshift_rdelm, inshift_wrelm;
   logic [CW-1:0]     inshift_count;
   logic [N*IW-1:0]   inparallel_instr;
   logic [N-1:0]      inparallel_first, inparallel_valid;
   logic [N*EW-1:0]   inparallel_rdelm, inparallel_wrelm;
   logic [N*CW-1:0]   inparallel_count;
   logic              rdelm_add_sub, wrelm_add_sub, count_add_sub;
   logic [EW-1:0]     rdelm_valuetoadd, wrelm_valuetoadd;
   logic [CW-1:0]     count_valuetoadd;
   logic [N*IW-1:0]   instr;
   logic [N-1:0]      first, valid, done;
   logic [N*EW-1:0]   rdelm, wrelm;
   logic [N*CW-1:0]   count;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   always #5 clk = ~clk;

   vdispatcher_multi #(
      .NUMSLOTS   (N),
      .INSTRWIDTH (IW),
      .ELMWIDTH   (EW),
      .CNTWIDTH   (CW)
   ) dut (
      .clk              (clk),
      .resetn           (resetn),
      .shift            (shift),
      .rotate           (rotate),
      .load             (load),
      .squash           (squash),
      .increment        (increment),
      .inshift_instr    (inshift_instr),
      .inshift_first    (inshift_first),
      .inshift_rdelm    (inshift_rdelm),
      .inshift_wrelm    (inshift_wrelm),
      .inshift_count    (inshift_count),
      .inshift_valid    (inshift_valid),
      .inparallel_instr (inparallel_instr),
      .inparallel_first (inparallel_first),
      .inparallel_rdelm (inparallel_rdelm),
      .inparallel_wrelm (inparallel_wrelm),
      .inparallel_count (inparallel_count),
      .inparallel_valid (inparallel_valid),
      .rdelm_add_sub    (rdelm_add_sub),
      .wrelm_add_sub    (wrelm_add_sub),
      .count_add_sub    (count_add_sub),
      .rdelm_valuetoadd (rdelm_valuetoadd),
      .wrelm_valuetoadd (wrelm_valuetoadd),
      .count_valuetoadd (count_valuetoadd),
      .instr            (instr),
      .first            (first),
      .rdelm            (rdelm),
      .wrelm            (wrelm),
      .count            (count),
      .valid            (valid),
      .done             (done)
   );

   task automatic check(input string tag, input logic [N*IW-1:0] got, input logic [N*IW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic slot_t mk(input int unsigned i_instr, input int unsigned i_first,
                                input int unsigned i_rd, input int unsigned i_wr,
                                input int unsigned i_cnt, input int unsigned i_val);
      slot_t s;
      s.instr = IW'(i_instr);
      s.first = i_first[0];
      s.rdelm = EW'(i_rd);
      s.wrelm = EW'(i_wr);
      s.count = CW'(i_cnt);
      s.valid = i_val[0];
      return s;
   endfunction

   function automatic slot_t get_slot(input int unsigned i);
      slot_t s;
      s.instr = instr[i*IW +: IW];
      s.first = first[i];
      s.rdelm = rdelm[i*EW +: EW];
      s.wrelm = wrelm[i*EW +: EW];
      s.count = count[i*CW +: CW];
      s.valid = valid[i];
      return s;
   endfunction

   task automatic check_slot(input string tag, input int unsigned i, input slot_t exp);
      slot_t g;
      g = get_slot(i);
      check($sformatf("%s_s%0d_instr", tag, i), g.instr, exp.instr);
      check($sformatf("%s_s%0d_first", tag, i), g.first, exp.first);
      check($sformatf("%s_s%0d_rdelm", tag, i), g.rdelm, exp.rdelm);
      check($sformatf("%s_s%0d_wrelm", tag, i), g.wrelm, exp.wrelm);
      check($sformatf("%s_s%0d_count", tag, i), g.count, exp.count);
      check($sformatf("%s_s%0d_valid", tag, i), g.valid, exp.valid);
   endtask

   task automatic set_par(input int unsigned i, input slot_t s);
      inparallel_instr[i*IW +: IW] = s.instr;
      inparallel_first[i]          = s.first;
      inparallel_rdelm[i*EW +: EW] = s.rdelm;
      inparallel_wrelm[i*EW +: EW] = s.wrelm;
      inparallel_count[i*CW +: CW] = s.count;
      inparallel_valid[i]          = s.valid;
   endtask

   task automatic idle();
      shift = 1'b0; rotate = 1'b0; load = 1'b0;
      squash = '0; increment = '0;
      inshift_instr = '0; inshift_first = 1'b0; inshift_rdelm = '0;
      inshift_wrelm = '0; inshift_count = '0; inshift_valid = 1'b0;
      rdelm_add_sub = ADD; wrelm_add_sub = ADD; count_add_sub = ADD;
      rdelm_valuetoadd = '0; wrelm_valuetoadd = '0; count_valuetoadd = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_instr"}, instr, '0);
      check({tag, "_first"}, first, '0);
      check({tag, "_rdelm"}, rdelm, '0);
      check({tag, "_wrelm"}, wrelm, '0);
      check({tag, "_count"}, count, '0);
      check({tag, "_valid"}, valid, '0);
      check({tag, "_done"},  done,  '0);
   endtask

   initial begin
      resetn = 1'b0;
      idle();
      inparallel_instr = '0; inparallel_first = '0; inparallel_rdelm = '0;
      inparallel_wrelm = '0; inparallel_count = '0; inparallel_valid = '0;

      // power-on reset
      #12;
      check_all_zero("por");
      resetn = 1'b1;
      tick();

      // shift fill: slot i ends with k = 4-i
      shift = 1'b1; inshift_valid = 1'b1; inshift_first = 1'b1;
      for (int unsigned k = 1; k <= 4; k++) begin
         inshift_instr = IW'(k);
         inshift_rdelm = EW'(k);
         inshift_wrelm = EW'(k + 10);
         inshift_count = CW'(k);
         tick();
      end
      for (int unsigned i = 0; i < N; i++)
         check_slot("fill", i, mk(4 - i, 1, 4 - i, 14 - i, 4 - i, 1));
      check("fill_done", done, 4'b0000);

      // rotate: tail wraps to head, inshift data ignored
      idle();
      shift = 1'b1; rotate = 1'b1;
      inshift_instr = IW'(9); inshift_valid = 1'b1;
      tick();
      check_slot("rot", 0, mk(1, 1, 1, 11, 1, 1));
      check("rot_s1", instr[1*IW +: IW], 4);
      check("rot_s2", instr[2*IW +: IW], 3);
      check("rot_s3", instr[3*IW +: IW], 2);

      // rotate without shift holds
      idle();
      rotate = 1'b1;
      tick();
      check("rotnoshift_s0", instr[0*IW +: IW], 1);
      check("rotnoshift_s1", instr[1*IW +: IW], 4);

      // parallel load
      idle();
      for (int unsigned i = 0; i < N; i++)
         set_par(i, mk(10 + i, 1, i * 5, 20 + i, i + 1, 1));
      load = 1'b1;
      tick();
      for (int unsigned i = 0; i < N; i++)
         check_slot("load", i, mk(10 + i, 1, i * 5, 20 + i, i + 1, 1));

      // increment travels with slot1 into slot2
      idle();
      shift = 1'b1; increment = 4'b0010;
      rdelm_valuetoadd = 6'd2; wrelm_valuetoadd = 6'd3; count_valuetoadd = 4'd1;
      inshift_instr = IW'(7); inshift_first = 1'b1; inshift_rdelm = 6'd9;
      inshift_wrelm = 6'd9; inshift_count = 4'd9; inshift_valid = 1'b0;
      tick();
      check_slot("incshift", 0, mk(7, 1, 9, 9, 9, 0));
      check_slot("incshift", 1, mk(10, 1, 0, 20, 1, 1));
      check_slot("incshift", 2, mk(11, 0, 7, 24, 3, 1));
      check_slot("incshift", 3, mk(12, 1, 10, 22, 3, 1));

      // count down to zero, then one more step
      idle();
      set_par(0, mk(20, 1, 0, 0, 3, 1));
      set_par(1, mk(21, 1, 0, 0, 3, 0));
      set_par(2, mk(22, 1, 0, 0, 0, 1));
      set_par(3, mk(23, 1, 0, 0, 0, 0));
      load = 1'b1;
      tick();
      idle();
      increment = 4'b0011;
      count_add_sub = SUB; count_valuetoadd = 4'd1;
      rdelm_add_sub = SUB; rdelm_valuetoadd = 6'd1;
      tick();
      tick();
      check("cd2_count0", count[0 +: CW], 1);
      check("cd2_done", done, 4'b0100);
      tick();
      check_slot("cd3", 0, mk(20, 0, 61, 0, 0, 1));
      check_slot("cd3", 1, mk(21, 1, 0, 0, 3, 0));
      check("cd3_done", done, 4'b0101);
      tick();
      check("cd4_rdelm0", rdelm[0 +: EW], 60);
`ifdef VDISPATCHER_COUNT_SATURATE_EN
      check("cd4_count0", count[0 +: CW], 0);
      check("cd4_done", done, 4'b0101);
`else
      check("cd4_count0", count[0 +: CW], 15);
      check("cd4_done", done, 4'b0100);
`endif

      // count addition overflow
      idle();
      set_par(0, mk(40, 1, 0, 0, 14, 1));
      load = 1'b1;
      tick();
      idle();
      increment = 4'b0001; count_valuetoadd = 4'd3;
      tick();
`ifdef VDISPATCHER_COUNT_SATURATE_EN
      check("ovf_count0", count[0 +: CW], 15);
`else
      check("ovf_count0", count[0 +: CW], 1);
`endif

      // load beats shift; squash clears valid; increment ignored on load
      idle();
      for (int unsigned i = 0; i < N; i++)
         set_par(i, mk(30 + i, 0, i + 1, i + 2, i + 3, 1));
      load = 1'b1; shift = 1'b1; squash = 4'b0001; increment = 4'b1111;
      rdelm_valuetoadd = 6'd1; wrelm_valuetoadd = 6'd1; count_valuetoadd = 4'd1;
      inshift_instr = IW'(99); inshift_valid = 1'b1;
      tick();
      for (int unsigned i = 0; i < N; i++)
         check_slot("prio", i, mk(30 + i, 0, i + 1, i + 2, i + 3, (i == 0) ? 0 : 1));

      // squash and increment on the same slot
      idle();
      squash = 4'b0010; increment = 4'b0010;
      rdelm_valuetoadd = 6'd1; wrelm_valuetoadd = 6'd1; count_valuetoadd = 4'd1;
      tick();
      check_slot("sqinc", 1, mk(31, 0, 3, 4, 5, 0));
      check_slot("sqinc", 2, mk(32, 0, 3, 4, 5, 1));

      // an invalid slot is never incremented
      squash = 4'b0000;
      tick();
      check_slot("invinc", 1, mk(31, 0, 3, 4, 5, 0));

      // asynchronous reset mid-cycle
      idle();
      @(posedge clk);
      #3;
      resetn = 1'b0;
      #1;
      check_all_zero("arst");
      shift = 1'b1; inshift_instr = IW'(5); inshift_valid = 1'b1;
      tick();
      check_all_zero("arst_hold");
      idle();
      #2;
      resetn = 1'b1;
      tick();
      check_all_zero("arst_rel");
      shift = 1'b1; inshift_instr = IW'(5); inshift_valid = 1'b1; inshift_count = 4'd2;
      tick();
      check_slot("post", 0, mk(5, 0, 0, 0, 2, 1));
      check("post_s1_valid", valid[1], 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
